spi_mem_master: RTL and testbench

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

---
 rtl/spi_mem_pkg.sv | 24 ++
 rtl/spi_sck_gen.sv | 51 +++++
 rtl/spi_mem_master.sv | 113 +++++++++++
 tb/tb_spi_mem_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI memory master.
package spi_mem_pkg;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam int         FRAME_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } state_t;

    // Opcode, address high, address low, then write data (zero filler on reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        we,
        input logic [15:0] addr,
        input logic [7:0]  wdata
    );
        return {(we ? OP_WRITE : OP_READ), addr, (we ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV clk cycles per half period, with
// strobes marking the clk edge at which SCK will rise or fall.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ph_q, ph_d;
    logic          wrap;

    assign wrap   = en_i && (cnt_q == LAST);
    assign rise_o = wrap && !ph_q;
    assign fall_o = wrap && ph_q;
    assign sck_o  = ph_q;

    // Disabling parks the divider at the start of a low phase.
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (!en_i) begin
            cnt_d = '0;
            ph_d  = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            ph_d  = !ph_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// Single-byte SPI memory master: CPU request/response in, 32-bit mode-0 frame out.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int            BW       = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam int            GW       = $clog2(2 * CLK_DIV + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV - 1);

    state_t                  state_q, state_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    we_q;
    logic [7:0]              rdata_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [7:0]              rx_q;

    logic accept;
    logic sck_rise, sck_fall;
    logic last_bit;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_SHIFT),
        .sck_o  (spi_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign last_bit  = sck_fall && (bit_q == BIT_LAST);

    assign spi_cs_n  = (state_q != ST_SHIFT);
    assign spi_mosi  = (state_q == ST_SHIFT) && frame_q[FRAME_BITS-1];
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)             state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)           state_d = ST_DONE;
            ST_DONE:                          state_d = ST_GAP;
            ST_GAP:   if (gap_q == GAP_LAST)  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_d = bit_q;
        if (accept) begin
            bit_d = '0;
        end else if (sck_fall) begin
            bit_d = bit_q + BW'(1);
        end
        gap_d = (state_q == ST_GAP) ? gap_q + GW'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            gap_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            if (accept) begin
                we_q <= req_we;
            end
            // The final MISO bit was captured a half period before this edge.
            if (last_bit) begin
                rdata_q <= we_q ? 8'h00 : rx_q;
            end
        end
    end

    // Datapath shift registers carry no reset; outputs are gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= build_frame(req_we, req_addr, req_wdata);
        end else if (sck_fall) begin
            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
        end
        if (sck_rise) begin
            rx_q <= {rx_q[6:0], spi_miso};
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: CLK_DIV=2 and CLK_DIV=1 instances against a cycle-timeline model.
module tb_spi_mem_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        cs_n      [2];
    logic        sck       [2];
    logic        mosi      [2];
    logic        miso      [2];
    logic [7:0]  mem_resp  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mem_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_mem_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Timeline model: outputs derived from cycle offset after acceptance.
    bit          m_active [2] = '{1'b0, 1'b0};
    int          m_t0     [2];
    logic [31:0] m_frame  [2];
    logic [7:0]  m_resp   [2];
    logic [7:0]  m_rdata  [2] = '{8'h00, 8'h00};
    logic        m_we     [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   d, c, k;
            logic e_ready, e_cs, e_sck, e_mosi, e_rv, miso_v;
            d       = (i == 0) ? 2 : 1;
            e_ready = 1'b0;
            e_cs    = 1'b1;
            e_sck   = 1'b0;
            e_mosi  = 1'b0;
            e_rv    = 1'b0;
            miso_v  = 1'b0;
            if (rst) begin
                m_active[i] = 1'b0;
                m_rdata[i]  = 8'h00;
            end else begin
                if (m_active[i]) begin
                    c = cyc - m_t0[i];
                    if (c >= 1 && c <= 64 * d) begin
                        k      = (c - 1) / (2 * d);
                        e_cs   = 1'b0;
                        e_sck  = (((c - 1) / d) % 2) == 1;
                        e_mosi = m_frame[i][31 - k];
                        if (k >= 24) miso_v = m_resp[i][31 - k];
                    end else if (c == 64 * d + 1) begin
                        e_rv       = 1'b1;
                        m_rdata[i] = m_we[i] ? 8'h00 : m_resp[i];
                    end else if (c >= 64 * d + 2 + 2 * d) begin
                        m_active[i] = 1'b0;
                    end
                end
                if (!m_active[i]) e_ready = 1'b1;
            end
            chk("req_ready", i, 32'(req_ready[i]), 32'(e_ready));
            chk("cs_n",      i, 32'(cs_n[i]),      32'(e_cs));
            chk("sck",       i, 32'(sck[i]),       32'(e_sck));
            chk("mosi",      i, 32'(mosi[i]),      32'(e_mosi));
            chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rv));
            chk("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(m_rdata[i]));
            if (!rst && e_ready && req_valid[i]) begin
                m_active[i] = 1'b1;
                m_t0[i]     = cyc;
                m_we[i]     = req_we[i];
                m_resp[i]   = mem_resp[i];
                m_frame[i]  = {(req_we[i] ? 8'h02 : 8'h03), req_addr[i],
                               (req_we[i] ? req_wdata[i] : 8'h00)};
            end
            miso[i] = miso_v;
        end
    end

    // Event recorder used by the literal checks.
    logic [31:0] mosi_cap [2];
    logic        prev_sck [2] = '{1'b0, 1'b0};
    int          acc_last [2];
    int          acc_prev [2];
    int          acc_cnt  [2] = '{0, 0};
    int          rsp_cyc  [2];
    logic [7:0]  rsp_data [2];
    int          rsp_cnt  [2] = '{0, 0};
    int          cs_low   [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_n[i] && sck[i] && !prev_sck[i]) mosi_cap[i] = {mosi_cap[i][30:0], mosi[i]};
            prev_sck[i] = sck[i];
            if (req_valid[i] && req_ready[i]) begin
                acc_prev[i] = acc_last[i];
                acc_last[i] = cyc;
                acc_cnt[i]++;
            end
            if (rsp_valid[i]) begin
                rsp_cyc[i]  = cyc;
                rsp_data[i] = rsp_rdata[i];
                rsp_cnt[i]++;
            end
            if (!cs_n[i]) cs_low[i]++;
        end
    end

    task automatic wait_accept(input int i);
        int n0;
        n0 = acc_cnt[i];
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (acc_cnt[i] != n0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("accept");
    endtask

    task automatic wait_rsp(input int i);
        int n0;
        n0 = rsp_cnt[i];
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt[i] != n0) return;
        end
        timeout("rsp_valid");
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (req_ready[i]) return;
        end
        timeout("idle");
    endtask

    task automatic drive(input int i, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] resp);
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        mem_resp[i]  = resp;
        req_valid[i] = 1'b1;
    endtask

    task automatic send(input int i, input logic we, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] resp);
        @(posedge clk);
        #1;
        drive(i, we, addr, wdata, resp);
        wait_accept(i);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        int c0, t0, rc, a0;
        logic [7:0] first_data;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0000;
            req_wdata[i] = 8'h00;
            mem_resp[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", 0, 32'(req_ready[0]), 32'h1);

        // Read 0x1234 returning 0xA5
        c0 = cs_low[0];
        send(0, 1'b0, 16'h1234, 8'h00, 8'hA5);
        wait_rsp(0);
        chk("rd_latency", 0, 32'(rsp_cyc[0] - acc_last[0]), 32'd129);
        chk("rd_data",    0, 32'(rsp_data[0]), 32'h0000_00A5);
        chk("rd_frame",   0, mosi_cap[0], 32'h0312_3400);
        chk("rd_cs_low",  0, 32'(cs_low[0] - c0), 32'd128);
        wait_idle(0);

        // Write 0x5A to 0xBEEF; memory drives 0xC3 which must be ignored
        c0 = cs_low[0];
        send(0, 1'b1, 16'hBEEF, 8'h5A, 8'hC3);
        wait_rsp(0);
        chk("wr_latency", 0, 32'(rsp_cyc[0] - acc_last[0]), 32'd129);
        chk("wr_data",    0, 32'(rsp_data[0]), 32'h0);
        chk("wr_frame",   0, mosi_cap[0], 32'h02BE_EF5A);
        chk("wr_cs_low",  0, 32'(cs_low[0] - c0), 32'd128);
        wait_idle(0);

        // req_valid held across two reads
        @(posedge clk);
        #1;
        drive(0, 1'b0, 16'h0010, 8'h00, 8'h81);
        wait_accept(0);
        mem_resp[0] = 8'h7E;
        wait_rsp(0);
        first_data = rsp_data[0];
        rc = rsp_cyc[0];
        wait_accept(0);
        req_valid[0] = 1'b0;
        chk("b2b_first_data", 0, 32'(first_data), 32'h81);
        chk("b2b_accept_gap", 0, 32'(acc_last[0] - acc_prev[0]), 32'd134);
        chk("b2b_gap_cycles", 0, 32'(acc_last[0] - rc - 1), 32'd4);
        wait_rsp(0);
        chk("b2b_second_data", 0, 32'(rsp_data[0]), 32'h7E);
        wait_idle(0);

        // Second request raised during SHIFT of the first
        send(0, 1'b0, 16'h0100, 8'h00, 8'h11);
        a0 = acc_cnt[0];
        repeat (48) @(posedge clk);
        #1;
        drive(0, 1'b1, 16'h0200, 8'h77, 8'h00);
        wait_rsp(0);
        chk("busy_no_accept", 0, 32'(acc_cnt[0]), 32'(a0));
        chk("busy_first_data", 0, 32'(rsp_data[0]), 32'h11);
        chk("busy_first_frame", 0, mosi_cap[0], 32'h0301_0000);
        wait_accept(0);
        req_valid[0] = 1'b0;
        chk("busy_accept_at", 0, 32'(acc_last[0] - acc_prev[0]), 32'd134);
        wait_rsp(0);
        chk("busy_second_frame", 0, mosi_cap[0], 32'h0202_0077);
        chk("busy_second_data", 0, 32'(rsp_data[0]), 32'h0);
        wait_idle(0);

        // Reset at cycle 40 of a read
        send(0, 1'b0, 16'h4242, 8'h00, 8'h99);
        t0 = acc_last[0];
        while (cyc < t0 + 40) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b1;
        #1;
        chk("rst_cs_n", 0, 32'(cs_n[0]), 32'h1);
        chk("rst_sck",  0, 32'(sck[0]),  32'h0);
        rc = rsp_cnt[0];
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ready_after", 0, 32'(req_ready[0]), 32'h1);
        repeat (200) @(negedge clk);
        chk("rst_no_rsp", 0, 32'(rsp_cnt[0]), 32'(rc));

        // CLK_DIV=1 read at 0xFFFF returning 0x3C
        c0 = cs_low[1];
        send(1, 1'b0, 16'hFFFF, 8'h00, 8'h3C);
        wait_rsp(1);
        chk("div1_latency", 1, 32'(rsp_cyc[1] - acc_last[1]), 32'd65);
        chk("div1_data",    1, 32'(rsp_data[1]), 32'h3C);
        chk("div1_frame",   1, mosi_cap[1], 32'h03FF_FF00);
        chk("div1_cs_low",  1, 32'(cs_low[1] - c0), 32'd64);
        wait_idle(1);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
